// File: rtl/eth_rx_pkg.sv
// Shared constants, speed encodings and FSM state type for the GMII receive framer.
package eth_rx_pkg;

  localparam logic [7:0] ETH_PRE = 8'h55;
  localparam logic [7:0] ETH_SFD = 8'hD5;

  localparam logic [1:0] SPD_10  = 2'b00;
  localparam logic [1:0] SPD_100 = 2'b01;
  localparam logic [1:0] SPD_1G  = 2'b10;

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_e;

  // 2'b11 is not a nibble speed, so it falls through to byte-wide operation.
  function automatic logic is_nibble_mode(input logic [1:0] spd);
    return (spd == SPD_10) || (spd == SPD_100);
  endfunction

endpackage

// File: rtl/gmii_nibble_pack.sv
// Pairs low-then-high nibbles into bytes for 10/100 operation; phase is held
// at zero while clr is high so every frame starts on a low nibble.
module gmii_nibble_pack (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       nib_vld,
  input  logic [3:0] nib,
  output logic       byte_vld,
  output logic [7:0] byte_data,
  output logic       odd
);

  logic       phase_q, phase_d;
  logic [3:0] lo_q, lo_d;

  always_comb begin
    phase_d   = phase_q;
    lo_d      = lo_q;
    byte_vld  = 1'b0;
    byte_data = {nib, lo_q};
    if (clr) begin
      phase_d = 1'b0;
    end else if (nib_vld) begin
      if (phase_q) begin
        byte_vld = 1'b1;
        phase_d  = 1'b0;
      end else begin
        lo_d    = nib;
        phase_d = 1'b1;
      end
    end
  end

  assign odd = phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      lo_q    <= 4'h0;
    end else begin
      phase_q <= phase_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: rtl/gmii_rx_frame_align.sv
// GMII receive framer: strips preamble/SFD, emits payload bytes with tlast/tuser
// and per-frame stat pulses. `GMII_RX_INBAND_STATUS_EN adds RGMII in-band link status.
module gmii_rx_frame_align
  import eth_rx_pkg::*;
#(
  parameter int PREAMBLE_MIN = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic [1:0] speed,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       stat_rx_frame,
  output logic       stat_rx_bad_frame,
  output logic       stat_rx_preamble_err,
  output state_e     dbg_state
`ifdef GMII_RX_INBAND_STATUS_EN
  ,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       link_full_duplex
`endif
);

  localparam logic [3:0] PRE_MIN = 4'(PREAMBLE_MIN);

  state_e     state_q, state_d;
  logic [1:0] spd_q, spd_d;
  logic [3:0] pre_cnt_q, pre_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;
  logic       er_seen_q, er_seen_d;
  logic [7:0] tdata_q, tdata_d;
  logic       tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic       stat_frame_q, stat_frame_d, stat_bad_q, stat_bad_d;
  logic       stat_perr_q, stat_perr_d;

  logic       nib_mode, pre_hit, sfd_hit, frame_bad, byte_rdy;
  logic [3:0] pairs;
  logic [7:0] unit_byte, pk_byte;
  logic       pk_byte_vld, pk_odd;

  // The live speed input only matters on the IDLE cycle that latches it.
  assign nib_mode = is_nibble_mode((state_q == IDLE) ? speed : spd_q);
  assign pre_hit  = nib_mode ? (gmii_rxd[3:0] == ETH_PRE[3:0]) : (gmii_rxd == ETH_PRE);
  assign sfd_hit  = nib_mode ? (gmii_rxd[3:0] == ETH_SFD[7:4]) : (gmii_rxd == ETH_SFD);
  // In nibble mode pre_cnt counts 0x5 nibbles; the last one is the SFD low half.
  assign pairs    = nib_mode ? ((pre_cnt_q - 4'd1) >> 1) : pre_cnt_q;

  gmii_nibble_pack u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state_q != PAYLOAD),
    .nib_vld   ((state_q == PAYLOAD) && gmii_rx_dv && nib_mode),
    .nib       (gmii_rxd[3:0]),
    .byte_vld  (pk_byte_vld),
    .byte_data (pk_byte),
    .odd       (pk_odd)
  );

  assign unit_byte = nib_mode ? pk_byte : gmii_rxd;
  assign byte_rdy  = nib_mode ? pk_byte_vld : 1'b1;
  assign frame_bad = er_seen_q | pk_odd | ~hold_vld_q;

  always_comb begin
    state_d      = state_q;
    spd_d        = spd_q;
    pre_cnt_d    = pre_cnt_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    er_seen_d    = er_seen_q;
    tdata_d      = 8'h00;
    tvalid_d     = 1'b0;
    tlast_d      = 1'b0;
    tuser_d      = 1'b0;
    stat_frame_d = 1'b0;
    stat_bad_d   = 1'b0;
    stat_perr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        pre_cnt_d  = 4'd0;
        hold_vld_d = 1'b0;
        er_seen_d  = 1'b0;
        if (gmii_rx_dv) begin
          spd_d = speed;
          if (pre_hit) begin
            state_d   = PREAMBLE;
            pre_cnt_d = 4'd1;
          end else if (sfd_hit && !nib_mode && (PRE_MIN == 4'd0)) begin
            state_d = PAYLOAD;
          end else begin
            state_d     = DROP;
            stat_perr_d = 1'b1;
          end
        end
      end
      PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
        end else if (pre_hit) begin
          pre_cnt_d = (pre_cnt_q == 4'hF) ? pre_cnt_q : pre_cnt_q + 4'd1;
        end else if (sfd_hit && (pairs >= PRE_MIN)) begin
          state_d = PAYLOAD;
        end else begin
          state_d     = DROP;
          stat_perr_d = 1'b1;
        end
      end
      PAYLOAD: begin
        if (!gmii_rx_dv) begin
          state_d      = IDLE;
          stat_frame_d = 1'b1;
          stat_bad_d   = frame_bad;
          tvalid_d     = hold_vld_q;
          tlast_d      = hold_vld_q;
          tuser_d      = hold_vld_q & frame_bad;
          tdata_d      = hold_q;
        end else begin
          if (gmii_rx_er) er_seen_d = 1'b1;
          // One-byte hold lets the final byte carry tlast once dv drops.
          if (byte_rdy) begin
            tvalid_d   = hold_vld_q;
            tdata_d    = hold_q;
            hold_d     = unit_byte;
            hold_vld_d = 1'b1;
          end
        end
      end
      DROP: begin
        if (!gmii_rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      spd_q        <= 2'b00;
      pre_cnt_q    <= 4'd0;
      hold_q       <= 8'h00;
      hold_vld_q   <= 1'b0;
      er_seen_q    <= 1'b0;
      tdata_q      <= 8'h00;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      stat_frame_q <= 1'b0;
      stat_bad_q   <= 1'b0;
      stat_perr_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      spd_q        <= spd_d;
      pre_cnt_q    <= pre_cnt_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      er_seen_q    <= er_seen_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      stat_frame_q <= stat_frame_d;
      stat_bad_q   <= stat_bad_d;
      stat_perr_q  <= stat_perr_d;
    end
  end

  assign m_axis_tdata         = tdata_q;
  assign m_axis_tvalid        = tvalid_q;
  assign m_axis_tlast         = tlast_q;
  assign m_axis_tuser         = tuser_q;
  assign stat_rx_frame        = stat_frame_q;
  assign stat_rx_bad_frame    = stat_bad_q;
  assign stat_rx_preamble_err = stat_perr_q;
  assign dbg_state            = state_q;

`ifdef GMII_RX_INBAND_STATUS_EN
  logic       link_up_q, link_up_d, link_fd_q, link_fd_d;
  logic [1:0] link_spd_q, link_spd_d;

  // Inter-frame idle carries the PHY's RGMII in-band status on rxd[3:0].
  always_comb begin
    link_up_d  = link_up_q;
    link_spd_d = link_spd_q;
    link_fd_d  = link_fd_q;
    if (!gmii_rx_dv && !gmii_rx_er) begin
      link_up_d  = gmii_rxd[0];
      link_spd_d = gmii_rxd[2:1];
      link_fd_d  = gmii_rxd[3];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_up_q  <= 1'b0;
      link_spd_q <= 2'b00;
      link_fd_q  <= 1'b0;
    end else begin
      link_up_q  <= link_up_d;
      link_spd_q <= link_spd_d;
      link_fd_q  <= link_fd_d;
    end
  end

  assign link_up          = link_up_q;
  assign link_speed       = link_spd_q;
  assign link_full_duplex = link_fd_q;
`endif

endmodule

// File: tb/tb_gmii_rx_frame_align.sv
// Scoreboard bench for gmii_rx_frame_align: a frame-level reference model pushes
// expected beats and stat counts; a negedge monitor pops and compares.
module tb_gmii_rx_frame_align;
  import eth_rx_pkg::*;

  localparam int PMIN = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] gmii_rxd = 8'h00;
  logic       gmii_rx_dv = 1'b0;
  logic       gmii_rx_er = 1'b0;
  logic [1:0] speed = SPD_1G;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic       stat_rx_frame, stat_rx_bad_frame, stat_rx_preamble_err;
  state_e     dbg_state;
`ifdef GMII_RX_INBAND_STATUS_EN
  logic       link_up, link_full_duplex;
  logic [1:0] link_speed;
`endif

  gmii_rx_frame_align #(.PREAMBLE_MIN(PMIN)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .gmii_rxd             (gmii_rxd),
    .gmii_rx_dv           (gmii_rx_dv),
    .gmii_rx_er           (gmii_rx_er),
    .speed                (speed),
    .m_axis_tdata         (m_axis_tdata),
    .m_axis_tvalid        (m_axis_tvalid),
    .m_axis_tlast         (m_axis_tlast),
    .m_axis_tuser         (m_axis_tuser),
    .stat_rx_frame        (stat_rx_frame),
    .stat_rx_bad_frame    (stat_rx_bad_frame),
    .stat_rx_preamble_err (stat_rx_preamble_err),
    .dbg_state            (dbg_state)
`ifdef GMII_RX_INBAND_STATUS_EN
    ,
    .link_up              (link_up),
    .link_speed           (link_speed),
    .link_full_duplex     (link_full_duplex)
`endif
  );

  // ---------------- clock / reset ----------------
  always #4 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] fr_unit[$];
  logic       fr_er[$];
  logic [9:0] exp_q[$];
  int n_checks = 0, n_fail = 0;
  int exp_frame = 0, exp_bad = 0, exp_perr = 0;
  int got_frame = 0, got_bad = 0, got_perr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level parse: run of preamble units, then SFD check, then payload.
  task automatic model_frame(input logic [1:0] spd);
    bit         g1;
    int         n, i, len, nn;
    logic [7:0] pre_v, sfd_v, u;
    logic [7:0] bytes[$];
    logic [3:0] lo;
    bit         er, bad, ok;
    g1    = !is_nibble_mode(spd);
    pre_v = g1 ? 8'h55 : 8'h05;
    sfd_v = g1 ? 8'hD5 : 8'h0D;
    len   = fr_unit.size();
    n = 0; i = 0; nn = 0; er = 0; lo = 4'h0;
    while (i < len) begin
      u = g1 ? fr_unit[i] : {4'h0, fr_unit[i][3:0]};
      if (u != pre_v) break;
      n++; i++;
    end
    if (i == len) return;
    u  = g1 ? fr_unit[i] : {4'h0, fr_unit[i][3:0]};
    ok = (u == sfd_v) && (g1 ? (n >= PMIN) : (n >= 1 && (n - 1) / 2 >= PMIN));
    if (!ok) begin
      exp_perr++;
      return;
    end
    for (int k = i + 1; k < len; k++) begin
      er = er | fr_er[k];
      if (g1) bytes.push_back(fr_unit[k]);
      else begin
        if (nn % 2 == 1) bytes.push_back({fr_unit[k][3:0], lo});
        else lo = fr_unit[k][3:0];
        nn++;
      end
    end
    bad = er || (!g1 && (nn % 2 == 1)) || (bytes.size() == 0);
    exp_frame++;
    if (bad) exp_bad++;
    for (int j = 0; j < bytes.size(); j++) begin
      if (j == bytes.size() - 1) exp_q.push_back({bad, 1'b1, bytes[j]});
      else exp_q.push_back({2'b00, bytes[j]});
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_frame(input logic [1:0] spd, input int gap, input bit gap_er);
    for (int k = 0; k < fr_unit.size(); k++) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b1;
      gmii_rx_er = fr_er[k];
      gmii_rxd   = is_nibble_mode(spd) ? {4'($urandom_range(0, 15)), fr_unit[k][3:0]} : fr_unit[k];
      speed      = (k == 0) ? spd : 2'($urandom_range(0, 3));
    end
    for (int k = 0; k < gap; k++) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b0;
      gmii_rx_er = gap_er && (k == 0);
      gmii_rxd   = 8'($urandom);
      speed      = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic send(input logic [1:0] spd, input int gap, input bit gap_er);
    model_frame(spd);
    drive_frame(spd, gap, gap_er);
  endtask

  task automatic clear_frame();
    fr_unit.delete();
    fr_er.delete();
  endtask

  task automatic add_unit(input logic [7:0] u, input bit e);
    fr_unit.push_back(u);
    fr_er.push_back(e);
  endtask

  // Preamble+SFD helper: 1G bytes, or nibbles (n_pre fives then D).
  task automatic add_header(input logic [1:0] spd, input int n_pre);
    if (is_nibble_mode(spd)) begin
      for (int k = 0; k < n_pre; k++) add_unit(8'h05, 1'b0);
      add_unit(8'h0D, 1'b0);
    end else begin
      for (int k = 0; k < n_pre; k++) add_unit(8'h55, 1'b0);
      add_unit(8'hD5, 1'b0);
    end
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_stat_frame"}, got_frame, exp_frame);
    check({tag, "_stat_bad"}, got_bad, exp_bad);
    check({tag, "_stat_perr"}, got_perr, exp_perr);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tlast"}, m_axis_tlast, 0);
    check({tag, "_tuser"}, m_axis_tuser, 0);
    check({tag, "_tdata"}, m_axis_tdata, 0);
    check({tag, "_stats"}, {stat_rx_frame, stat_rx_bad_frame, stat_rx_preamble_err}, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- monitor ----------------
  logic [9:0] exp_beat;
  always @(negedge clk) begin
    if (rst_n) begin
      got_frame += int'(stat_rx_frame);
      got_bad   += int'(stat_rx_bad_frame);
      got_perr  += int'(stat_rx_preamble_err);
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h last %0b user %0b with none expected",
                   m_axis_tdata, m_axis_tlast, m_axis_tuser);
        end else begin
          exp_beat = exp_q.pop_front();
          check("beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_beat);
          if (m_axis_tlast) begin
            check("tlast_stat_frame", stat_rx_frame, 1);
            check("tlast_stat_bad", stat_rx_bad_frame, m_axis_tuser);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int         npre, npay, cut;
    logic [1:0] spd;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1G, 7 preamble bytes, payload 01..40
    clear_frame();
    add_header(SPD_1G, 7);
    for (int k = 1; k <= 64; k++) add_unit(8'(k), 1'b0);
    send(SPD_1G, 4, 1'b0);
    wait_drain("g1_64");
    check_stats("g1_64");

    // 100M, 15 fives + D, payload nibbles 2,1,4,3
    clear_frame();
    add_header(SPD_100, 15);
    add_unit(8'h02, 1'b0); add_unit(8'h01, 1'b0);
    add_unit(8'h04, 1'b0); add_unit(8'h03, 1'b0);
    send(SPD_100, 4, 1'b0);
    wait_drain("m100");
    check_stats("m100");

    // 1G, rx_er on one payload byte
    clear_frame();
    add_header(SPD_1G, 7);
    for (int k = 0; k < 12; k++) add_unit(8'(8'hA0 + k), k == 5);
    send(SPD_1G, 4, 1'b0);
    wait_drain("g1_er");
    check_stats("g1_er");

    // short preamble, then a good frame right behind it
    clear_frame();
    add_header(SPD_1G, 1);
    for (int k = 0; k < 6; k++) add_unit(8'(8'h30 + k), 1'b0);
    send(SPD_1G, 1, 1'b0);
    clear_frame();
    add_header(SPD_1G, 3);
    for (int k = 0; k < 5; k++) add_unit(8'(8'h70 + k), 1'b0);
    send(SPD_1G, 4, 1'b0);
    wait_drain("pre_err");
    check_stats("pre_err");

    // 10M, odd payload nibble count; end of frame by false carrier
    clear_frame();
    add_header(SPD_10, 15);
    for (int k = 1; k <= 5; k++) add_unit(8'(k), 1'b0);
    send(SPD_10, 4, 1'b1);
    wait_drain("m10_odd");
    check_stats("m10_odd");

    // zero-byte frame: dv falls right after SFD
    clear_frame();
    add_header(SPD_1G, 7);
    send(SPD_1G, 4, 1'b0);
    wait_drain("zero");
    check_stats("zero");

    // reset during payload byte 10: bytes 0..7 were already out
    clear_frame();
    add_header(SPD_1G, 7);
    for (int k = 0; k < 10; k++) add_unit(8'(8'hC0 + k), 1'b0);
    for (int k = 0; k < 8; k++) exp_q.push_back({2'b00, 8'(8'hC0 + k)});
    drive_frame(SPD_1G, 0, 1'b0);
    @(posedge clk); #1;
    gmii_rxd = 8'hCA;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (3) @(posedge clk);
    #1;
    gmii_rx_dv = 1'b0;
    rst_n = 1'b1;
    wait_drain("midrst");
    clear_frame();
    add_header(SPD_1G, 7);
    for (int k = 0; k < 9; k++) add_unit(8'($urandom), 1'b0);
    send(SPD_1G, 4, 1'b0);
    wait_drain("post_rst");
    check_stats("post_rst");

    // randomized frames
    for (int f = 0; f < 120; f++) begin
      clear_frame();
      spd = 2'($urandom_range(0, 3));
      if (is_nibble_mode(spd)) begin
        npre = $urandom_range(0, 17);
        for (int k = 0; k < npre; k++) add_unit(8'h05, 1'b0);
        add_unit(($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 15)) : 8'h0D, 1'b0);
        npay = $urandom_range(0, 41);
        for (int k = 0; k < npay; k++) add_unit(8'($urandom_range(0, 15)), $urandom_range(0, 29) == 0);
      end else begin
        npre = $urandom_range(0, 8);
        for (int k = 0; k < npre; k++) add_unit(8'h55, 1'b0);
        add_unit(($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hD5, 1'b0);
        npay = $urandom_range(0, 24);
        for (int k = 0; k < npay; k++) add_unit(8'($urandom), $urandom_range(0, 29) == 0);
      end
      if ($urandom_range(0, 7) == 0 && npre > 0)
        fr_unit[$urandom_range(0, npre - 1)] = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        cut = $urandom_range(0, fr_unit.size());
        while (fr_unit.size() > cut) begin
          void'(fr_unit.pop_back());
          void'(fr_er.pop_back());
        end
      end
      send(spd, $urandom_range(1, 4), $urandom_range(0, 3) == 0);
      if (f % 10 == 9) begin
        wait_drain("rand");
        check_stats("rand");
      end
    end

    wait_drain("final");
    check_stats("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
